// File: rtl/qemu_bus_initiator_if.sv
// Host-command, host-response and memory-bus signal bundle for
// qemu_bus_initiator.
//   cmd_*  : host -> initiator access commands (valid/ready)
//   rsp_*  : initiator -> host responses (valid/ready)
//   bus_*  : initiator <-> memory responder (req/ack, word addressed)
// Modport master is the initiator's view; slave is the host+responder view.
interface qemu_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_offset;
  logic [31:0] cmd_data;
  logic        cmd_we;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_we;
  logic        rsp_err;

  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_offset, cmd_data, cmd_we, rsp_ready, bus_ack, bus_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_we, rsp_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_offset, cmd_data, cmd_we, rsp_ready, bus_ack, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_we, rsp_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/qemu_bus_initiator.sv
// Word-addressed memory access initiator.
// Buffers host commands in a FIFO, issues them one at a time on a req/ack
// bus and returns one response (read data / write completion + error) per
// command, strictly in order.
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus_if     : command, response and memory bus signals (master modport)
//   busy       : FSM active or commands queued
//   fifo_count : occupied command FIFO entries
module qemu_bus_initiator #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic                              clock,
  input  logic                              reset_n,
  qemu_bus_initiator_if.master              bus_if,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Entry layout: {we, word address, write data}
  logic [62:0]   entry_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          bus_we_q, bus_we_d;
  logic [29:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_we_q, rsp_we_d;
  logic          rsp_err_q, rsp_err_d;

  logic          cmd_ready;
  logic          push;
  logic          pop;
  logic [62:0]   head;

  // Byte-lane bits of the offset have no meaning for whole-word accesses.
  logic          unused_offset_bits;
  assign unused_offset_bits = ^bus_if.cmd_offset[1:0];

  assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
  assign push      = bus_if.cmd_valid && cmd_ready;
  assign head      = entry_mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) begin
      entry_mem[wr_ptr_q] <= {bus_if.cmd_we, bus_if.cmd_offset[31:2], bus_if.cmd_data};
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop                                = 1'b1;
          {bus_we_d, bus_addr_d, bus_wdata_d} = head;
          tmo_d                              = '0;
          state_d                            = S_REQ;
        end
      end
      S_REQ: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (bus_if.bus_ack) begin
          rsp_data_d = bus_we_q ? '0 : bus_if.bus_rdata;
          rsp_err_d  = 1'b0;
          rsp_we_d   = bus_we_q;
          state_d    = S_RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = bus_we_q ? '0 : ERR_DATA;
          rsp_err_d  = 1'b1;
          rsp_we_d   = bus_we_q;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus_if.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus_if.cmd_ready = cmd_ready;
  assign bus_if.bus_req   = (state_q == S_REQ);
  assign bus_if.bus_we    = bus_we_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;
  assign bus_if.rsp_valid = (state_q == S_RESP);
  assign bus_if.rsp_data  = rsp_data_q;
  assign bus_if.rsp_we    = rsp_we_q;
  assign bus_if.rsp_err   = rsp_err_q;
  assign busy             = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count       = count_q;

endmodule

// File: tb/tb_qemu_bus_initiator.sv
module tb_qemu_bus_initiator;
  logic       clock;
  logic       reset_n;
  logic       busy;
  logic [2:0] fifo_count;
  int         tests_run;
  int         tests_failed;

  qemu_bus_initiator_if bif ();

  qemu_bus_initiator #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(16),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus_if    (bif.master),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] off, input logic [31:0] d, input logic we);
    bif.cmd_valid  = 1'b1;
    bif.cmd_offset = off;
    bif.cmd_data   = d;
    bif.cmd_we     = we;
    tick();
    bif.cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    tests_run++; if (bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL rst_bus_req: got %0h expected 0", bif.bus_req); end
    tests_run++; if (bif.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %0h expected 0", bif.rsp_valid); end
    tests_run++; if (bif.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_cmd_ready: got %0h expected 1", bif.cmd_ready); end
    tests_run++; if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL rst_fifo_count: got %0d expected 0", fifo_count); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    tests_run++; if ({bif.bus_addr, bif.bus_wdata, bif.bus_we} !== 63'd0) begin tests_failed++; $display("FAIL rst_bus_fields: got %0h expected 0", {bif.bus_addr, bif.bus_wdata, bif.bus_we}); end
    tests_run++; if ({bif.rsp_data, bif.rsp_we, bif.rsp_err} !== 34'd0) begin tests_failed++; $display("FAIL rst_rsp_fields: got %0h expected 0", {bif.rsp_data, bif.rsp_we, bif.rsp_err}); end
    reset_n = 1'b1;
    tick();
    tests_run++; if (bif.bus_req !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_release_idle: got req=%0h busy=%0h expected 0/0", bif.bus_req, busy); end
  endtask

  task automatic test_write_read();
    bif.rsp_ready = 1'b1;
    push_cmd(32'h10, 32'hCAFE_F00D, 1'b1);
    tests_run++; if (bif.bus_req !== 1'b0 || fifo_count !== 3'd1) begin tests_failed++; $display("FAIL wr_accept_cycle: got req=%0h cnt=%0d expected 0/1", bif.bus_req, fifo_count); end
    tick();
    tests_run++; if (bif.bus_req !== 1'b1) begin tests_failed++; $display("FAIL wr_req_rise: got %0h expected 1", bif.bus_req); end
    tests_run++; if (bif.bus_addr !== 30'h4 || bif.bus_we !== 1'b1 || bif.bus_wdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL wr_bus_fields: got addr=%0h we=%0h wdata=%0h expected 4/1/cafef00d", bif.bus_addr, bif.bus_we, bif.bus_wdata); end
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h1234_5678;
    tick();
    bif.bus_ack   = 1'b0;
    tests_run++; if (bif.rsp_valid !== 1'b1 || bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_valid: got valid=%0h req=%0h expected 1/0", bif.rsp_valid, bif.bus_req); end
    tests_run++; if (bif.rsp_we !== 1'b1 || bif.rsp_data !== 32'h0 || bif.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_fields: got we=%0h data=%0h err=%0h expected 1/0/0", bif.rsp_we, bif.rsp_data, bif.rsp_err); end
    tick();
    tests_run++; if (bif.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_drop: got %0h expected 0", bif.rsp_valid); end

    push_cmd(32'h13, 32'h0, 1'b0);
    tests_run++; if (bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL rd_accept_cycle: got %0h expected 0", bif.bus_req); end
    tick();
    tests_run++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 30'h4 || bif.bus_we !== 1'b0) begin tests_failed++; $display("FAIL rd_bus_fields: got req=%0h addr=%0h we=%0h expected 1/4/0", bif.bus_req, bif.bus_addr, bif.bus_we); end
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'hCAFE_F00D;
    tick();
    bif.bus_ack   = 1'b0;
    tests_run++; if (bif.rsp_valid !== 1'b1 || bif.rsp_we !== 1'b0 || bif.rsp_data !== 32'hCAFE_F00D || bif.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rd_rsp_fields: got v=%0h we=%0h data=%0h err=%0h expected 1/0/cafef00d/0", bif.rsp_valid, bif.rsp_we, bif.rsp_data, bif.rsp_err); end
    tick();
    tests_run++; if (bif.rsp_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rd_done_idle: got valid=%0h busy=%0h expected 0/0", bif.rsp_valid, busy); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_off;
    int          k;
    bif.rsp_ready = 1'b1;
    bif.bus_ack   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bif.cmd_valid  = 1'b1;
      bif.cmd_offset = 32'h100 + 32'(i) * 4;
      bif.cmd_data   = 32'hD000_0000 + 32'(i);
      bif.cmd_we     = 1'b1;
      tick();
    end
    tests_run++; if (fifo_count !== 3'd4 || bif.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL full_count_ready: got cnt=%0d ready=%0h expected 4/0", fifo_count, bif.cmd_ready); end
    bif.cmd_offset = 32'hDEAD_0000;
    bif.cmd_data   = 32'hDEAD_DEAD;
    for (int i = 0; i < 3; i++) tick();
    tests_run++; if (fifo_count !== 3'd4 || bif.cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL full_no_push: got cnt=%0d ready=%0h expected 4/0", fifo_count, bif.cmd_ready); end
    bif.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      while (bif.bus_req !== 1'b1 && k < 20) begin tick(); k++; end
      tests_run++; if (bif.bus_req !== 1'b1) begin tests_failed++; $display("FAIL order_req_wait[%0d]: got %0h expected 1", i, bif.bus_req); end
      exp_off = 32'h100 + 32'(i) * 4;
      tests_run++; if (bif.bus_addr !== exp_off[31:2] || bif.bus_wdata !== 32'hD000_0000 + 32'(i)) begin tests_failed++; $display("FAIL order_fields[%0d]: got addr=%0h wdata=%0h expected %0h/%0h", i, bif.bus_addr, bif.bus_wdata, exp_off[31:2], 32'hD000_0000 + 32'(i)); end
      bif.bus_ack = 1'b1;
      tick();
      bif.bus_ack = 1'b0;
      tests_run++; if (bif.rsp_valid !== 1'b1 || bif.rsp_we !== 1'b1 || bif.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL order_rsp[%0d]: got v=%0h we=%0h err=%0h expected 1/1/0", i, bif.rsp_valid, bif.rsp_we, bif.rsp_err); end
      tick();
    end
    tick();
    tick();
    tests_run++; if (busy !== 1'b0 || fifo_count !== 3'd0 || bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL full_drained: got busy=%0h cnt=%0d req=%0h expected 0/0/0", busy, fifo_count, bif.bus_req); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    bif.rsp_ready = 1'b1;
    bif.bus_ack   = 1'b0;
    push_cmd(32'h20, 32'h0, 1'b0);
    tick();
    req_cycles = 0;
    while (bif.bus_req === 1'b1 && req_cycles < 40) begin req_cycles++; tick(); end
    tests_run++; if (req_cycles !== 16) begin tests_failed++; $display("FAIL tmo_req_cycles: got %0d expected 16", req_cycles); end
    tests_run++; if (bif.rsp_valid !== 1'b1 || bif.rsp_err !== 1'b1 || bif.rsp_data !== 32'hFFFF_FFFF || bif.rsp_we !== 1'b0) begin tests_failed++; $display("FAIL tmo_rsp: got v=%0h err=%0h data=%0h we=%0h expected 1/1/ffffffff/0", bif.rsp_valid, bif.rsp_err, bif.rsp_data, bif.rsp_we); end
    tick();
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h1234_5678;
    tick();
    bif.bus_ack   = 1'b0;
    tick();
    tests_run++; if (bif.rsp_valid !== 1'b0 || busy !== 1'b0 || bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL tmo_late_ack: got v=%0h busy=%0h req=%0h expected 0/0/0", bif.rsp_valid, busy, bif.bus_req); end
  endtask

  task automatic test_ack_last_cycle();
    bif.rsp_ready = 1'b1;
    push_cmd(32'h24, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    tests_run++; if (bif.bus_req !== 1'b1) begin tests_failed++; $display("FAIL ack16_still_req: got %0h expected 1", bif.bus_req); end
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'hA5A5_5A5A;
    tick();
    bif.bus_ack   = 1'b0;
    tests_run++; if (bif.rsp_valid !== 1'b1 || bif.rsp_err !== 1'b0 || bif.rsp_data !== 32'hA5A5_5A5A) begin tests_failed++; $display("FAIL ack16_rsp: got v=%0h err=%0h data=%0h expected 1/0/a5a55a5a", bif.rsp_valid, bif.rsp_err, bif.rsp_data); end
    tick();
  endtask

  task automatic test_rsp_backpressure();
    bif.rsp_ready = 1'b0;
    push_cmd(32'h30, 32'h0000_0011, 1'b1);
    push_cmd(32'h34, 32'h0, 1'b0);
    tests_run++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 30'hC) begin tests_failed++; $display("FAIL bp_first_req: got req=%0h addr=%0h expected 1/c", bif.bus_req, bif.bus_addr); end
    bif.bus_ack = 1'b1;
    tick();
    bif.bus_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (bif.rsp_valid !== 1'b1 || bif.rsp_we !== 1'b1 || bif.rsp_data !== 32'h0 || bif.rsp_err !== 1'b0 || bif.bus_req !== 1'b0 || fifo_count !== 3'd1) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%0h we=%0h data=%0h err=%0h req=%0h cnt=%0d expected 1/1/0/0/0/1", i, bif.rsp_valid, bif.rsp_we, bif.rsp_data, bif.rsp_err, bif.bus_req, fifo_count);
      end
      tick();
    end
    bif.rsp_ready = 1'b1;
    tick();
    tests_run++; if (bif.rsp_valid !== 1'b0 || bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL bp_accept_idle: got v=%0h req=%0h expected 0/0", bif.rsp_valid, bif.bus_req); end
    tick();
    tests_run++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 30'hD || bif.bus_we !== 1'b0) begin tests_failed++; $display("FAIL bp_second_req: got req=%0h addr=%0h we=%0h expected 1/d/0", bif.bus_req, bif.bus_addr, bif.bus_we); end
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h0000_BEEF;
    tick();
    bif.bus_ack   = 1'b0;
    tests_run++; if (bif.rsp_valid !== 1'b1 || bif.rsp_data !== 32'h0000_BEEF || bif.rsp_we !== 1'b0) begin tests_failed++; $display("FAIL bp_second_rsp: got v=%0h data=%0h we=%0h expected 1/beef/0", bif.rsp_valid, bif.rsp_data, bif.rsp_we); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    bif.rsp_ready = 1'b1;
    bif.bus_ack   = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(32'h200 + 32'(i) * 4, 32'(i), 1'b1);
    tests_run++; if (bif.bus_req !== 1'b1 || fifo_count !== 3'd3) begin tests_failed++; $display("FAIL rstmid_pre: got req=%0h cnt=%0d expected 1/3", bif.bus_req, fifo_count); end
    reset_n = 1'b0;
    #1;
    tests_run++; if (bif.bus_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req_drop: got %0h expected 0", bif.bus_req); end
    tick();
    reset_n = 1'b1;
    tick();
    tests_run++; if (fifo_count !== 3'd0 || bif.rsp_valid !== 1'b0 || busy !== 1'b0 || bif.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_after: got cnt=%0d v=%0h busy=%0h ready=%0h expected 0/0/0/1", fifo_count, bif.rsp_valid, busy, bif.cmd_ready); end
    bif.bus_ack = 1'b1;
    tick();
    bif.bus_ack = 1'b0;
    tick();
    tests_run++; if (bif.rsp_valid !== 1'b0 || bif.bus_req !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_late_ack: got v=%0h req=%0h busy=%0h expected 0/0/0", bif.rsp_valid, bif.bus_req, busy); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset_n        = 1'b0;
    bif.cmd_valid  = 1'b0;
    bif.cmd_offset = '0;
    bif.cmd_data   = '0;
    bif.cmd_we     = 1'b0;
    bif.rsp_ready  = 1'b1;
    bif.bus_ack    = 1'b0;
    bif.bus_rdata  = '0;

    test_reset();
    test_write_read();
    test_fifo_full();
    test_timeout();
    test_ack_last_cycle();
    test_rsp_backpressure();
    test_reset_mid_access();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/qemu_bus_initiator.md
Name: qemu_bus_initiator

Overview:
- Synthesizable initiator for the word-addressed memory access protocol: (offset, data, we) packets issued to a memory-side responder.
- Accepts access commands from the host-bridge side and buffers them in a small command FIFO.
- Drives each command onto a req/ack memory bus, one at a time, in order.
- Returns one response per command (read data or write completion, plus error flag) to the host side.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 16, max cycles bus_req may wait for bus_ack before error completion (>=1)
ERR_DATA, 32'hFFFF_FFFF, rsp_data returned on a timed-out read

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_offset  in  32  byte offset
cmd_data  in  32  write data (ignored for reads)
cmd_we  in  1  1=write, 0=read
rsp_valid  out  1  response available
rsp_ready  in  1  host accepts response
rsp_data  out  32  read data; 0 for writes
rsp_we  out  1  echo of command we
rsp_err  out  1  1=access timed out
bus_req  out  1  memory access request
bus_we  out  1  access direction
bus_addr  out  30  word address = cmd_offset[31:2]
bus_wdata  out  32  write data
bus_ack  in  1  responder completion, single-cycle pulse
bus_rdata  in  32  read data, valid in bus_ack cycle
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset (async assert, sync deassert use): FIFO empty, fifo_count=0, cmd_ready=1, FSM=IDLE, bus_req=0, rsp_valid=0, rsp_err=0, rsp_we=0, bus_we=0, bus_addr=0, bus_wdata=0, rsp_data=0, busy=0, timeout counter=0.
- Reset mid-access drops bus_req immediately and discards FIFO contents and any pending response; a late bus_ack after reset is ignored.
- cmd_ready = (fifo_count != FIFO_DEPTH), registered-state based. Push on cmd_valid && cmd_ready.
- When full, no push even if a pop happens in the same cycle. Push and pop in the same cycle with non-full FIFO leaves fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Ordering is strictly FIFO.
- Offset bits [1:0] are ignored; the access is always a whole 32-bit word.
- FSM states IDLE, REQ, RESP:
  - IDLE: if FIFO non-empty, pop head into bus_addr/bus_we/bus_wdata, clear timeout counter, go to REQ. bus_req=1 from the next cycle.
  - REQ: bus_req=1; bus_addr, bus_we and bus_wdata held stable.
    - bus_ack=1: capture rsp_data = bus_rdata for a read or 0 for a write, rsp_err=0, rsp_we=bus_we, go to RESP. bus_req=0 next cycle.
    - Else increment the counter. When the counter reaches TIMEOUT_CYCLES with no ack, set rsp_err=1, rsp_data = ERR_DATA for a read or 0 for a write, go to RESP. bus_req=0 next cycle.
    - bus_ack in the same cycle the counter would expire wins (normal completion).
  - RESP: rsp_valid=1, response fields stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE; rsp_valid=0 next cycle.
- bus_ack while not in REQ is ignored.
- Latency: command pushed into an empty FIFO at cycle 0 gives pop in IDLE at cycle 1 and bus_req high at cycle 2. A zero-wait ack at cycle 2 gives rsp_valid at cycle 3.
- Back-to-back commands take at least 3 cycles each, with one IDLE cycle between consecutive accesses.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
- Write 0x10 data 0xCAFEF00D with ack on 1st req cycle, then read 0x10 with bus_rdata=0xCAFEF00D -> bus_addr=0x4 both times; responses (we=1, data=0, err=0) then (we=0, data=0xCAFEF00D, err=0); bus_req rises 2 cycles after each accept.
- Push 5 commands back-to-back with bus_ack held 0 and rsp_ready=1, FIFO_DEPTH=4 -> cmd_ready=0 when fifo_count=4; commands issue in push order once ack resumes; no command lost or duplicated.
- Read 0x20 with no ack, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles then 0; rsp_err=1, rsp_data=0xFFFFFFFF; a later bus_ack pulse is ignored.
- bus_ack arrives on the 16th REQ cycle -> normal completion, err=0, data=bus_rdata.
- rsp_ready held 0 for 10 cycles with 2 commands queued -> rsp fields stable and no new bus_req until the response is accepted; then the second access proceeds.
- Assert reset_n=0 while bus_req=1 with 3 queued -> bus_req drops in the same cycle; after release fifo_count=0, rsp_valid=0, busy=0, cmd_ready=1.
